// File: rtl/uart_tx_stim.sv
// ============================================================================
// Module   : uart_tx_stim
// Brief    : FIFO-fed 8N1 UART transmitter (bit = 16 x divisor clocks).
//            Optional parity bit when UART_TX_STIM_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_stim #(
    parameter int FIFO_AW = 4,
    parameter int DIV_W   = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [DIV_W-1:0]   divisor_i,
    input  logic [7:0]         tx_data_i,
    input  logic               tx_valid_i,
`ifdef UART_TX_STIM_PARITY_EN
    input  logic               parity_odd_i,
`endif
    output logic               tx_ready_o,
    output logic               uart_tx_o,
    output logic               busy_o,
    output logic [FIFO_AW:0]   fifo_level_o,
    output logic               tx_done_o
);

    localparam int               c_DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] c_FULL  = (FIFO_AW + 1)'(c_DEPTH);
    localparam logic [FIFO_AW:0] c_LONE  = (FIFO_AW + 1)'(1);

`ifdef UART_TX_STIM_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;
`endif

    state_t             r_state;
    logic [7:0]         r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic               r_ready;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit_cnt;
    logic [3:0]         r_os_cnt;
    logic [DIV_W-1:0]   r_tick_cnt;
    logic [DIV_W-1:0]   r_div_m1;
    logic               r_tx;
    logic               r_done;
`ifdef UART_TX_STIM_PARITY_EN
    logic               r_par;
`endif

    logic               w_push;
    logic               w_pop;
    logic               w_tick;
    logic               w_bit_end;
    logic               w_done_nxt;
    logic [DIV_W-1:0]   w_div_m1;
    logic [7:0]         w_rd_data;
    logic [FIFO_AW:0]   w_level_nxt;

    assign w_div_m1  = (divisor_i == '0) ? '0 : divisor_i - DIV_W'(1);
    assign w_tick    = (r_tick_cnt == '0);
    assign w_bit_end = w_tick && (r_os_cnt == 4'd15);
    assign w_push    = tx_valid_i && r_ready;
    assign w_pop     = (r_level != '0) &&
                       ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
    assign w_rd_data = r_mem[r_rd_ptr];

    // Predict the final stop-bit clock one cycle early so tx_done_o is registered.
    assign w_done_nxt = (r_state == S_STOP) &&
                        (((r_tick_cnt == DIV_W'(1)) && (r_os_cnt == 4'd15)) ||
                         (w_tick && (r_div_m1 == '0) && (r_os_cnt == 4'd14)));

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + c_LONE;
            2'b01:   w_level_nxt = r_level - c_LONE;
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_push && !wb_rst_i) begin
            r_mem[r_wr_ptr] <= tx_data_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_ready    <= 1'b1;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_os_cnt   <= '0;
            r_tick_cnt <= '0;
            r_div_m1   <= '0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
`ifdef UART_TX_STIM_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            r_done  <= w_done_nxt;
            r_level <= w_level_nxt;
            r_ready <= (w_level_nxt != c_FULL);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (r_state != S_IDLE) begin
                if (w_tick) begin
                    r_tick_cnt <= r_div_m1;
                    r_os_cnt   <= r_os_cnt + 4'd1;
                end else begin
                    r_tick_cnt <= r_tick_cnt - DIV_W'(1);
                end
            end
            if (w_bit_end) begin
                case (r_state)
                    S_START: begin
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end
                    S_DATA: begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_STIM_PARITY_EN
                            r_state <= S_PARITY;
                            r_tx    <= r_par;
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_tx      <= r_shift[1];
                        end
                    end
`ifdef UART_TX_STIM_PARITY_EN
                    S_PARITY: begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end
`endif
                    S_STOP: begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end
                    default: ;
                endcase
            end
            // A pop overrides the STOP->IDLE move so frames run back-to-back.
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + FIFO_AW'(1);
                r_shift    <= w_rd_data;
                r_div_m1   <= w_div_m1;
                r_tick_cnt <= w_div_m1;
                r_os_cnt   <= '0;
                r_bit_cnt  <= '0;
                r_tx       <= 1'b0;
                r_state    <= S_START;
`ifdef UART_TX_STIM_PARITY_EN
                r_par      <= (^w_rd_data) ^ parity_odd_i;
`endif
            end
        end
    end

    assign tx_ready_o   = r_ready;
    assign uart_tx_o    = r_tx;
    assign tx_done_o    = r_done;
    assign fifo_level_o = r_level;
    assign busy_o       = (r_state != S_IDLE) || (r_level != '0);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_stim.sv
// ============================================================================
// Module   : tb_uart_tx_stim
// Brief    : Scoreboarded bench for uart_tx_stim with a serial-line monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_stim;

`ifdef UART_TX_STIM_PARITY_EN
    localparam int c_FBITS = 11;
`else
    localparam int c_FBITS = 10;
`endif
    localparam int c_DONE_LAT = 1 + 16 * c_FBITS;

    typedef struct {
        logic [7:0] data;
        int         bclk;
        logic       par;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] divisor = 16'd1;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        odd_sel = 1'b0;
    logic        tx_ready;
    logic        uart_tx;
    logic        busy;
    logic [4:0]  level;
    logic        tx_done;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   rx_cnt = 0;
    logic mon_en = 1'b1;
    exp_t sb_q[$];

    uart_tx_stim #(.FIFO_AW(4), .DIV_W(16)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .divisor_i    (divisor),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
`ifdef UART_TX_STIM_PARITY_EN
        .parity_odd_i (odd_sel),
`endif
        .tx_ready_o   (tx_ready),
        .uart_tx_o    (uart_tx),
        .busy_o       (busy),
        .fifo_level_o (level),
        .tx_done_o    (tx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offers one byte for a single clock; returns the acceptance cycle.
    task automatic push_byte(input logic [7:0] d, input int bclk, input logic to_sb, output int n);
        exp_t e;
        check_eq("ready_before_push", tx_ready, 1);
        n        = cyc;
        tx_data  = d;
        tx_valid = 1'b1;
        if (to_sb) begin
            e.data = d;
            e.bclk = bclk;
            e.par  = (^d) ^ odd_sel;
            sb_q.push_back(e);
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_done === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check_eq("done_timeout", 0, 1);
    endtask

    task automatic wait_rx(input int target, input int budget);
        for (int i = 0; i < budget && rx_cnt < target; i++) @(negedge clk);
        check_eq("rx_count", rx_cnt, target);
    endtask

    // Line monitor: samples mid-bit using the bit length the scoreboard expects.
    initial begin : g_mon
        exp_t       e;
        int         b;
        logic [7:0] rx;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && uart_tx === 1'b0) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_frame", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    b = e.bclk;
                    repeat (b / 2) @(negedge clk);
                    check_eq("rx_start", uart_tx, 0);
                    for (int i = 0; i < 8; i++) begin
                        repeat (b) @(negedge clk);
                        rx[i] = uart_tx;
                    end
                    check_eq("rx_data", rx, e.data);
`ifdef UART_TX_STIM_PARITY_EN
                    repeat (b) @(negedge clk);
                    check_eq("rx_parity", uart_tx, e.par);
`endif
                    repeat (b) @(negedge clk);
                    check_eq("rx_stop", uart_tx, 1);
                    repeat (b - b / 2 - 1) @(negedge clk);
                    rx_cnt++;
                end
            end
        end
    end

    initial begin : g_watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : g_main
        int n, n2, w1, w2, acc, lows, d0, rx_base;

        tick(3);
        check_eq("rst_tx", uart_tx, 1);
        check_eq("rst_ready", tx_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_done", tx_done, 0);
        rst = 1'b0;
        tick(2);

        // Single byte, divisor 1
        push_byte(8'h55, 16, 1'b1, n);
        check_eq("single_idle_n1", uart_tx, 1);
        tick(1);
        check_eq("single_start_n2", uart_tx, 0);
        tick(15);
        check_eq("single_start_n17", uart_tx, 0);
        tick(1);
        check_eq("single_bit0_n18", uart_tx, 1);
        tick(16);
        check_eq("single_bit1_n34", uart_tx, 0);
        wait_done(400, w1);
        check_eq("single_done_lat", w1 - n, c_DONE_LAT);
        check_eq("single_busy_at_done", busy, 1);
        tick(1);
        check_eq("single_busy_fall", busy, 0);
        check_eq("single_done_pulse", tx_done, 0);
        wait_rx(1, 200);

        // Back-to-back frames
        push_byte(8'hA5, 16, 1'b1, n);
        push_byte(8'h3C, 16, 1'b1, n2);
        wait_done(400, w1);
        tick(1);
        check_eq("b2b_no_gap", uart_tx, 0);
        wait_done(400, w2);
        check_eq("b2b_done_spacing", w2 - w1, 16 * c_FBITS);
        wait_rx(3, 400);

        // Divisor 0 behaves as 1
        divisor = 16'd0;
        push_byte(8'h96, 16, 1'b1, n);
        tick(16);
        check_eq("div0_start_n17", uart_tx, 0);
        tick(1);
        check_eq("div0_bit0_n18", uart_tx, 0);
        wait_done(400, w1);
        check_eq("div0_done_lat", w1 - n, c_DONE_LAT);
        wait_rx(4, 200);

        // Divisor change mid-frame applies to the next frame only
        divisor = 16'd1;
        push_byte(8'h12, 16, 1'b1, n);
        push_byte(8'h34, 32, 1'b1, n2);
        tick(40);
        divisor = 16'd2;
        wait_done(400, w1);
        check_eq("divchg_first_lat", w1 - n, c_DONE_LAT);
        wait_done(800, w2);
        check_eq("divchg_spacing", w2 - w1, 32 * c_FBITS);
        wait_rx(6, 400);

        // FIFO fill from reset with divisor 26
        rst = 1'b1;
        divisor = 16'd26;
        tick(2);
        rst = 1'b0;
        rx_base = rx_cnt;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            exp_t e;
            tx_data  = 8'h80 + 8'(i);
            tx_valid = 1'b1;
            if (tx_ready === 1'b1) begin
                e.data = tx_data;
                e.bclk = (acc == 0) ? 26 * 16 : 16;
                e.par  = (^tx_data) ^ odd_sel;
                sb_q.push_back(e);
                acc++;
            end
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check_eq("full_accepted", acc, 17);
        check_eq("full_level", level, 16);
        check_eq("full_ready", tx_ready, 0);
        divisor = 16'd1;
        tick(3);
        check_eq("full_ready_held", tx_ready, 0);
        wait_rx(rx_base + 17, 12000);
        tick(2);
        check_eq("full_drained_level", level, 0);
        check_eq("full_drained_busy", busy, 0);

        // Reset during DATA bit 3
        mon_en = 1'b0;
        push_byte(8'hFF, 16, 1'b0, n);
        push_byte(8'h11, 16, 1'b0, n2);
        push_byte(8'h22, 16, 1'b0, n2);
        push_byte(8'h33, 16, 1'b0, n2);
        tick(n + 72 - cyc);
        check_eq("rstmid_bit3_high", uart_tx, 1);
        check_eq("rstmid_level_pre", level, 3);
        d0 = done_cnt;
        rst = 1'b1;
        tick(1);
        check_eq("rstmid_tx", uart_tx, 1);
        check_eq("rstmid_level", level, 0);
        check_eq("rstmid_busy", busy, 0);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        check_eq("rstmid_line_idle", lows, 0);
        check_eq("rstmid_no_done", done_cnt, d0);
        mon_en = 1'b1;

`ifdef UART_TX_STIM_PARITY_EN
        // Parity: even sense then odd sense on 0x07
        rx_base = rx_cnt;
        odd_sel = 1'b0;
        push_byte(8'h07, 16, 1'b1, n);
        wait_done(400, w1);
        check_eq("par_even_done_lat", w1 - n, 177);
        wait_rx(rx_base + 1, 200);
        odd_sel = 1'b1;
        push_byte(8'h07, 16, 1'b1, n);
        wait_done(400, w1);
        check_eq("par_odd_done_lat", w1 - n, 177);
        wait_rx(rx_base + 2, 200);
`endif

        check_eq("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
